// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - data_mode encodings, sequencer states and access-size helper
package lsu_pkg;

    localparam logic [2:0] DM_B  = 3'b001;
    localparam logic [2:0] DM_H  = 3'b010;
    localparam logic [2:0] DM_W  = 3'b011;
    localparam logic [2:0] DM_BU = 3'b100;
    localparam logic [2:0] DM_HU = 3'b101;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2,
        RESP  = 2'd3
    } lsu_state_e;

    // Access size in bytes; 0 marks an illegal mode.
    function automatic logic [2:0] size_of(input logic [2:0] mode);
        case (mode)
            DM_B, DM_BU: size_of = 3'd1;
            DM_H, DM_HU: size_of = 3'd2;
            DM_W:        size_of = 3'd4;
            default:     size_of = 3'd0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_ctrl_if.sv
// rtl/lsu_ctrl_if.sv - word-organised data memory req/ack bus
interface lsu_ctrl_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );
endinterface

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - byte-enable/lane shifting for both beats and load extension
module lsu_align
    import lsu_pkg::*;
(
    input  logic [1:0]  off,
    input  logic [2:0]  mode,
    input  logic [31:0] wdata,
    input  logic [31:0] rd_lo,
    input  logic [23:0] rd_hi,
    output logic        split,
    output logic [3:0]  be0,
    output logic [3:0]  be1,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] load_data
);

    logic [2:0]  size;
    logic [3:0]  size_mask;
    logic [7:0]  mask8;
    logic [31:0] assembled;

    assign size      = size_of(mode);
    assign size_mask = 4'((5'd1 << size) - 5'd1);
    assign mask8     = {4'b0000, size_mask} << off;
    assign be0       = mask8[3:0];
    assign be1       = mask8[7:4];
    assign split     = |mask8[7:4];
    assign wdata0    = wdata << {off, 3'b000};

    // Bytes that spill past the word boundary restart at lane 0 of the next word.
    always_comb begin
        wdata1 = 32'd0;
        case (off)
            2'd1:    wdata1 = {24'd0, wdata[31:24]};
            2'd2:    wdata1 = {16'd0, wdata[31:16]};
            2'd3:    wdata1 = {8'd0,  wdata[31:8]};
            default: wdata1 = 32'd0;
        endcase
    end

    always_comb begin
        assembled = rd_lo;
        case (off)
            2'd1:    assembled = {rd_hi[7:0],  rd_lo[31:8]};
            2'd2:    assembled = {rd_hi[15:0], rd_lo[31:16]};
            2'd3:    assembled = {rd_hi[23:0], rd_lo[31:24]};
            default: assembled = rd_lo;
        endcase
    end

    always_comb begin
        load_data = assembled;
        case (mode)
            DM_B:    load_data = {{24{assembled[7]}}, assembled[7:0]};
            DM_BU:   load_data = {24'd0, assembled[7:0]};
            DM_H:    load_data = {{16{assembled[15]}}, assembled[15:0]};
            DM_HU:   load_data = {16'd0, assembled[15:0]};
            default: load_data = assembled;
        endcase
    end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store sequencer: one or two word beats, stall, timeout
module lsu_ctrl
    import lsu_pkg::*;
#(
    parameter int TO_CYCLES = 255,
    parameter int TO_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_vld,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [2:0]  data_mode,
    output logic        stall,
    output logic        rsp_vld,
    output logic [31:0] rsp_rdata,
    output logic        err,
    lsu_ctrl_if.master  mem
);

    localparam bit            TO_EN   = (TO_CYCLES != 0);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TO_CYCLES == 0) ? 0 : TO_CYCLES - 1);

    lsu_state_e      state_q, state_d;
    logic            we_q, split_q, to_q;
    logic [1:0]      off_q;
    logic [2:0]      mode_q;
    logic [31:0]     wdata_q, rd_lo_q;
    logic [23:0]     rd_hi_q;
    logic [TO_W-1:0] cnt_q;
    logic            req_q, mwe_q;
    logic [31:0]     addr_q, mwd_q;
    logic [3:0]      be_q;

    logic            idle, legal, accept, ack, timeout;
    logic            al_split;
    logic [3:0]      al_be0, al_be1;
    logic [31:0]     al_wdata0, al_wdata1, al_load;

    assign idle    = (state_q == IDLE);
    assign legal   = (size_of(data_mode) != 3'd0);
    assign ack     = mem.mem_ack & req_q;
    assign timeout = TO_EN & req_q & ~mem.mem_ack & (cnt_q == TO_LAST);

    // While idle the aligner looks at the incoming request so beat 0 can be registered on accept.
    lsu_align u_align (
        .off       (idle ? req_addr[1:0] : off_q),
        .mode      (idle ? data_mode     : mode_q),
        .wdata     (idle ? req_wdata     : wdata_q),
        .rd_lo     (rd_lo_q),
        .rd_hi     (rd_hi_q),
        .split     (al_split),
        .be0       (al_be0),
        .be1       (al_be1),
        .wdata0    (al_wdata0),
        .wdata1    (al_wdata1),
        .load_data (al_load)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        err     = 1'b0;
        rsp_vld = 1'b0;
        accept  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_vld && legal) begin
                    stall   = 1'b1;
                    accept  = 1'b1;
                    state_d = BEAT0;
                end else if (req_vld) begin
                    err = 1'b1;
                end
            end
            BEAT0: begin
                stall = 1'b1;
                if (ack)          state_d = split_q ? BEAT1 : RESP;
                else if (timeout) state_d = RESP;
            end
            BEAT1: begin
                stall = 1'b1;
                if (ack || timeout) state_d = RESP;
            end
            RESP: begin
                rsp_vld = 1'b1;
                err     = to_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            split_q <= 1'b0;
            to_q    <= 1'b0;
            off_q   <= 2'd0;
            mode_q  <= 3'd0;
            wdata_q <= 32'd0;
            rd_lo_q <= 32'd0;
            rd_hi_q <= 24'd0;
            cnt_q   <= '0;
            req_q   <= 1'b0;
            mwe_q   <= 1'b0;
            addr_q  <= 32'd0;
            mwd_q   <= 32'd0;
            be_q    <= 4'd0;
        end else begin
            case (state_q)
                IDLE: if (accept) begin
                    we_q    <= req_we;
                    split_q <= al_split;
                    to_q    <= 1'b0;
                    off_q   <= req_addr[1:0];
                    mode_q  <= data_mode;
                    wdata_q <= req_wdata;
                    rd_lo_q <= 32'd0;
                    rd_hi_q <= 24'd0;
                    cnt_q   <= '0;
                    req_q   <= 1'b1;
                    mwe_q   <= req_we;
                    addr_q  <= {req_addr[31:2], 2'b00};
                    mwd_q   <= al_wdata0;
                    be_q    <= al_be0;
                end
                BEAT0, BEAT1: begin
                    if (ack) begin
                        req_q <= 1'b0;
                        if (state_q == BEAT0) begin
                            rd_lo_q <= mem.mem_rdata;
                            if (split_q) begin
                                addr_q <= addr_q + 32'd4;
                                be_q   <= al_be1;
                                mwd_q  <= al_wdata1;
                            end
                        end else begin
                            rd_hi_q <= mem.mem_rdata[23:0];
                        end
                    end else if (timeout) begin
                        req_q <= 1'b0;
                        to_q  <= 1'b1;
                    end else if (req_q) begin
                        cnt_q <= cnt_q + TO_W'(1);
                    end else begin
                        // First BEAT1 cycle: request was dropped after beat 0's ack, raise it again.
                        req_q <= 1'b1;
                        cnt_q <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_rdata     = (state_q == RESP && !we_q && !to_q) ? al_load : 32'd0;
    assign mem.mem_req   = req_q;
    assign mem.mem_we    = mwe_q;
    assign mem.mem_addr  = addr_q;
    assign mem.mem_be    = be_q;
    assign mem.mem_wdata = mwd_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb/tb_lsu_ctrl.sv - directed self-checking bench for lsu_ctrl
module tb_lsu_ctrl;
    import lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_vld, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  data_mode;
    logic        stall, rsp_vld, err;
    logic [31:0] rsp_rdata;
    int          checks = 0;
    int          errors = 0;

    lsu_ctrl_if mif ();

    lsu_ctrl #(.TO_CYCLES(4), .TO_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_vld   (req_vld),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .data_mode (data_mode),
        .stall     (stall),
        .rsp_vld   (rsp_vld),
        .rsp_rdata (rsp_rdata),
        .err       (err),
        .mem       (mif)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d, input logic [2:0] m);
        req_vld = v; req_we = w; req_addr = a; req_wdata = d; data_mode = m;
        #1;
    endtask

    task automatic mem_rsp(input logic a, input logic [31:0] rd);
        mif.mem_ack = a; mif.mem_rdata = rd;
    endtask

    task automatic test_reset();
        checks++; if ({stall, rsp_vld, err, mif.mem_req, mif.mem_we} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b exp 00000", {stall, rsp_vld, err, mif.mem_req, mif.mem_we}); end
        checks++; if (mif.mem_addr !== 32'd0) begin errors++; $display("FAIL reset_addr got %h exp 00000000", mif.mem_addr); end
        checks++; if (mif.mem_be !== 4'd0) begin errors++; $display("FAIL reset_be got %b exp 0000", mif.mem_be); end
        checks++; if (mif.mem_wdata !== 32'd0 || rsp_rdata !== 32'd0) begin errors++; $display("FAIL reset_data got %h/%h exp 0/0", mif.mem_wdata, rsp_rdata); end
    endtask

    task automatic test_lw();
        drive(1, 0, 32'h100, 32'd0, DM_W);
        checks++; if (stall !== 1'b1 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL lw_req_cycle got stall=%b req=%b exp 1/0", stall, mif.mem_req); end
        step();
        checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b0 || stall !== 1'b1) begin errors++; $display("FAIL lw_beat0 got req=%b we=%b stall=%b exp 1/0/1", mif.mem_req, mif.mem_we, stall); end
        checks++; if (mif.mem_addr !== 32'h100 || mif.mem_be !== 4'b1111) begin errors++; $display("FAIL lw_addr_be got %h/%b exp 00000100/1111", mif.mem_addr, mif.mem_be); end
        mem_rsp(1, 32'hDEADBEEF);
        step();
        mem_rsp(0, 32'd0);
        checks++; if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL lw_rsp got vld=%b data=%h exp 1/deadbeef", rsp_vld, rsp_rdata); end
        checks++; if (stall !== 1'b0 || mif.mem_req !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL lw_resp_ctl got stall=%b req=%b err=%b exp 0/0/0", stall, mif.mem_req, err); end
        drive(0, 0, 32'd0, 32'd0, 3'd0);
        step();
        checks++; if (rsp_vld !== 1'b0) begin errors++; $display("FAIL lw_rsp_pulse got %b exp 0", rsp_vld); end
    endtask

    task automatic test_byte_loads();
        drive(1, 0, 32'h203, 32'd0, DM_B);
        step();
        checks++; if (mif.mem_addr !== 32'h200 || mif.mem_be !== 4'b1000) begin errors++; $display("FAIL lb_addr_be got %h/%b exp 00000200/1000", mif.mem_addr, mif.mem_be); end
        mem_rsp(1, 32'h80123456);
        step();
        mem_rsp(0, 32'd0);
        checks++; if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_sext got vld=%b data=%h exp 1/ffffff80", rsp_vld, rsp_rdata); end
        drive(0, 0, 32'd0, 32'd0, 3'd0);
        step();
        drive(1, 0, 32'h203, 32'd0, DM_BU);
        step();
        mem_rsp(1, 32'h80123456);
        step();
        mem_rsp(0, 32'd0);
        checks++; if (rsp_vld !== 1'b1 || rsp_rdata !== 32'h00000080) begin errors++; $display("FAIL lbu_zext got vld=%b data=%h exp 1/00000080", rsp_vld, rsp_rdata); end
        drive(0, 0, 32'd0, 32'd0, 3'd0);
        step();
    endtask

    task automatic test_split_store();
        drive(1, 1, 32'h103, 32'h0000A1B2, DM_H);
        step();
        checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1 || mif.mem_addr !== 32'h100 || mif.mem_be !== 4'b1000) begin errors++; $display("FAIL sh_beat0 got req=%b we=%b addr=%h be=%b exp 1/1/00000100/1000", mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_be); end
        checks++; if (mif.mem_wdata !== 32'hB2000000) begin errors++; $display("FAIL sh_wdata0 got %h exp b2000000", mif.mem_wdata); end
        mem_rsp(1, 32'd0);
        step();
        mem_rsp(0, 32'd0);
        checks++; if (mif.mem_req !== 1'b0 || stall !== 1'b1 || rsp_vld !== 1'b0) begin errors++; $display("FAIL sh_gap got req=%b stall=%b vld=%b exp 0/1/0", mif.mem_req, stall, rsp_vld); end
        step();
        checks++; if (mif.mem_req !== 1'b1 || mif.mem_we !== 1'b1 || mif.mem_addr !== 32'h104 || mif.mem_be !== 4'b0001) begin errors++; $display("FAIL sh_beat1 got req=%b we=%b addr=%h be=%b exp 1/1/00000104/0001", mif.mem_req, mif.mem_we, mif.mem_addr, mif.mem_be); end
        checks++; if (mif.mem_wdata !== 32'h000000A1) begin errors++; $display("FAIL sh_wdata1 got %h exp 000000a1", mif.mem_wdata); end
        mem_rsp(1, 32'd0);
        step();
        mem_rsp(0, 32'd0);
        checks++; if (rsp_vld !== 1'b1 || rsp_rdata !== 32'd0 || err !== 1'b0) begin errors++; $display("FAIL sh_rsp got vld=%b data=%h err=%b exp 1/00000000/0", rsp_vld, rsp_rdata, err); end
        drive(0, 0, 32'd0, 32'd0, 3'd0);
        step();
    endtask

    task automatic test_wrap_load();
        drive(1, 0, 32'hFFFFFFFE, 32'd0, DM_W);
        step();
        checks++; if (mif.mem_addr !== 32'hFFFFFFFC || mif.mem_be !== 4'b1100) begin errors++; $display("FAIL wrap_beat0 got %h/%b exp fffffffc/1100", mif.mem_addr, mif.mem_be); end
        mem_rsp(1, 32'h11225566);
        step();
        mem_rsp(0, 32'd0);
        step();
        checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h00000000 || mif.mem_be !== 4'b0011) begin errors++; $display("FAIL wrap_beat1 got req=%b addr=%h be=%b exp 1/00000000/0011", mif.mem_req, mif.mem_addr, mif.mem_be); end
        mem_rsp(1, 32'h77883344);
        step();
        mem_rsp(0, 32'd0);
        checks++; if (rsp_vld !== 1'b1 || rsp_rdata !== 32'h33441122) begin errors++; $display("FAIL wrap_rsp got vld=%b data=%h exp 1/33441122", rsp_vld, rsp_rdata); end
        drive(0, 0, 32'd0, 32'd0, 3'd0);
        step();
    endtask

    task automatic test_timeout();
        drive(1, 0, 32'h300, 32'd0, DM_W);
        step();
        step();
        step();
        step();
        checks++; if (mif.mem_req !== 1'b1 || rsp_vld !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL to_wait got req=%b vld=%b err=%b exp 1/0/0", mif.mem_req, rsp_vld, err); end
        step();
        checks++; if (err !== 1'b1 || rsp_vld !== 1'b1 || rsp_rdata !== 32'd0 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL to_abort got err=%b vld=%b data=%h req=%b exp 1/1/0/0", err, rsp_vld, rsp_rdata, mif.mem_req); end
        mem_rsp(1, 32'h12345678);
        drive(0, 0, 32'd0, 32'd0, 3'd0);
        step();
        mem_rsp(0, 32'd0);
        checks++; if (err !== 1'b0 || rsp_vld !== 1'b0 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL to_late_ack got err=%b vld=%b req=%b exp 0/0/0", err, rsp_vld, mif.mem_req); end
        drive(1, 0, 32'h104, 32'd0, DM_W);
        step();
        checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h104) begin errors++; $display("FAIL to_next_req got req=%b addr=%h exp 1/00000104", mif.mem_req, mif.mem_addr); end
        mem_rsp(1, 32'hCAFEF00D);
        step();
        mem_rsp(0, 32'd0);
        checks++; if (rsp_vld !== 1'b1 || rsp_rdata !== 32'hCAFEF00D || err !== 1'b0) begin errors++; $display("FAIL to_next_rsp got vld=%b data=%h err=%b exp 1/cafef00d/0", rsp_vld, rsp_rdata, err); end
        drive(0, 0, 32'd0, 32'd0, 3'd0);
        step();
    endtask

    task automatic test_illegal();
        drive(1, 0, 32'h100, 32'd0, 3'b110);
        checks++; if (err !== 1'b1 || stall !== 1'b0 || mif.mem_req !== 1'b0) begin errors++; $display("FAIL ill_req got err=%b stall=%b req=%b exp 1/0/0", err, stall, mif.mem_req); end
        drive(0, 0, 32'd0, 32'd0, 3'd0);
        step();
        checks++; if (err !== 1'b0 || mif.mem_req !== 1'b0 || rsp_vld !== 1'b0) begin errors++; $display("FAIL ill_after got err=%b req=%b vld=%b exp 0/0/0", err, mif.mem_req, rsp_vld); end
    endtask

    task automatic test_reset_mid();
        drive(1, 0, 32'h100, 32'd0, DM_W);
        step();
        step();
        checks++; if (mif.mem_req !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL rst_mid_wait got req=%b stall=%b exp 1/1", mif.mem_req, stall); end
        #2;
        rst_n = 1'b0;
        drive(0, 0, 32'd0, 32'd0, 3'd0);
        checks++; if (mif.mem_req !== 1'b0 || stall !== 1'b0 || mif.mem_be !== 4'd0) begin errors++; $display("FAIL rst_mid_drop got req=%b stall=%b be=%b exp 0/0/0000", mif.mem_req, stall, mif.mem_be); end
        mem_rsp(1, 32'h0BADCAFE);
        step();
        mem_rsp(0, 32'd0);
        rst_n = 1'b1;
        step();
        drive(1, 0, 32'h108, 32'd0, DM_HU);
        step();
        checks++; if (mif.mem_req !== 1'b1 || mif.mem_addr !== 32'h108 || mif.mem_be !== 4'b0011) begin errors++; $display("FAIL rst_mid_idle got req=%b addr=%h be=%b exp 1/00000108/0011", mif.mem_req, mif.mem_addr, mif.mem_be); end
        mem_rsp(1, 32'h1234F00D);
        step();
        mem_rsp(0, 32'd0);
        checks++; if (rsp_vld !== 1'b1 || rsp_rdata !== 32'h0000F00D) begin errors++; $display("FAIL rst_mid_next got vld=%b data=%h exp 1/0000f00d", rsp_vld, rsp_rdata); end
        drive(0, 0, 32'd0, 32'd0, 3'd0);
        step();
    endtask

    initial begin
        rst_n = 1'b0;
        mem_rsp(0, 32'd0);
        drive(0, 0, 32'd0, 32'd0, 3'd0);
        #2;
        test_reset();
        step();
        step();
        rst_n = 1'b1;
        step();
        test_lw();
        test_byte_loads();
        test_split_store();
        test_wrap_load();
        test_timeout();
        test_illegal();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
